// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter (uart_tx_fifo).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Users of this function reject a result below 2 at elaboration.
    function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; power-of-two depth, pointers wrap naturally.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_i,
    input  logic [Width-1:0]       wr_data_i,
    input  logic                   rd_i,
    output logic [Width-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int PtrW = $clog2(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: Depth must be a power of two and at least 2");
    end

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             push;
    logic             pop;

    // full/empty come from the pre-edge count, so a pop cannot make room for a same-cycle write.
    assign full_o    = (count_q == (PtrW + 1)'(Depth));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push      = wr_i && !full_o;
    assign pop       = rd_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser with back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ClockFrequency = 24_000_000,
    parameter int BaudRate       = 115_200,
    parameter int NrOfDataBits   = 8,
    parameter int NrOfStopBits   = 1,
    parameter int FifoDepth      = 8,
    parameter int ParityOdd      = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write,
    input  logic [NrOfDataBits-1:0] writeData,
    output logic                    full,
    output logic                    empty,
    output logic                    busy,
    output logic                    overflow,
    output logic                    tx
);

    localparam int ClocksPerBit = clocks_per_bit(ClockFrequency, BaudRate);
    localparam int BaudW        = $clog2(ClocksPerBit);
    localparam int BitW         = $clog2(NrOfDataBits + 1);
    localparam int CountW       = $clog2(FifoDepth) + 1;

    if (ClocksPerBit < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: ClockFrequency/BaudRate must be at least 2");
    end
    if (NrOfDataBits < 5 || NrOfDataBits > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: NrOfDataBits must be in 5..9");
    end
    if (NrOfStopBits != 1 && NrOfStopBits != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: NrOfStopBits must be 1 or 2");
    end
    if (ParityOdd != PARITY_EVEN && ParityOdd != PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_fifo: ParityOdd must be 0 or 1");
    end

    uart_state_e             state_q;
    logic [BaudW-1:0]        baud_q;
    logic [BitW-1:0]         bit_q;
    logic [NrOfDataBits-1:0] shift_q;
    logic                    tx_q;
    logic                    busy_q;
    logic                    overflow_q;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
`endif

    logic [NrOfDataBits-1:0] fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CountW-1:0]       fifo_count;
    logic                    frame_pending;
    logic                    bit_end;
    logic                    last_stop;
    logic                    pop;

    sync_fifo #(
        .Width (NrOfDataBits),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i     (clock),
        .rst_ni    (reset),
        .wr_i      (write),
        .wr_data_i (writeData),
        .rd_i      (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign frame_pending = (fifo_count != '0);
    assign bit_end       = (baud_q == BaudW'(ClocksPerBit - 1));
    assign last_stop     = (bit_q == BitW'(NrOfStopBits - 1));
    // Popping straight out of the final stop bit gives gap-free back-to-back frames.
    assign pop = frame_pending &&
                 ((state_q == IDLE) || (state_q == STOP && bit_end && last_stop));

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign tx       = tx_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            overflow_q <= write && fifo_full;
            if (pop) begin
                state_q  <= START;
                shift_q  <= fifo_rd_data;
                baud_q   <= '0;
                bit_q    <= '0;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_q <= (^fifo_rd_data) ^ 1'(ParityOdd);
`endif
            end else begin
                case (state_q)
                    IDLE: tx_q <= 1'b1;
                    START: begin
                        if (bit_end) begin
                            state_q <= DATA;
                            tx_q    <= shift_q[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_q == BitW'(NrOfDataBits - 1)) begin
                                bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                                state_q <= PARITY;
                                tx_q    <= parity_q;
`else
                                state_q <= STOP;
                                tx_q    <= 1'b1;
`endif
                            end else begin
                                bit_q   <= bit_q + BitW'(1);
                                shift_q <= shift_q >> 1;
                                tx_q    <= shift_q[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            if (last_stop) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                bit_q   <= '0;
                            end else begin
                                bit_q <= bit_q + BitW'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                if (state_q != IDLE) begin
                    baud_q <= bit_end ? '0 : baud_q + BaudW'(1);
                end
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered UART transmitter; successor to the single-shot UART transmitter used in the board-level clock design.
- Accepts bytes through a write strobe into an internal FIFO.
- Serialises them back-to-back with configurable data width, stop-bit count and optional parity.
- Sits between board logic (switches/keys, time-of-day formatter) and the UART_TXD pin.

Parameters:
ClockFrequency, 24_000_000, input clock frequency in Hz
BaudRate, 115_200, serial bit rate in baud; ClocksPerBit = ClockFrequency/BaudRate (integer division), must be >= 2
NrOfDataBits, 8, data bits per frame, legal range 5..9
NrOfStopBits, 1, stop bits per frame, legal values 1 or 2
FifoDepth, 8, FIFO entries, power of two, >= 2
ParityOdd, 0, 0 = even parity, 1 = odd parity (only used with UART_TX_PARITY_EN)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
write  input  1  one-cycle strobe: push writeData into FIFO
writeData  input  NrOfDataBits  byte to send
full  output  1  FIFO holds FifoDepth entries
empty  output  1  FIFO holds 0 entries
busy  output  1  frame in progress (state != IDLE)
overflow  output  1  one-cycle pulse: write dropped because full
tx  output  1  serial line, idle high

Behaviour:
- Reset (reset low, asynchronous):
  - tx=1, busy=0, full=0, empty=1, overflow=0.
  - FIFO pointers, count, baud counter, bit counter and shift register cleared; state=IDLE.
  - Reset mid-frame aborts the frame; tx is high immediately.
- FIFO write rule:
  - write && !full stores the entry.
  - write && full drops the data and pulses overflow for exactly one cycle.
  - full is evaluated on the pre-edge count, so a write into a full FIFO is dropped even if a pop occurs in the same cycle.
- FIFO pop: in IDLE with !empty, the FSM pops the head and loads the shift register in the same edge.
  - Simultaneous write and pop with count between 1 and FifoDepth-1: count unchanged.
- Latency: a write at edge k into an empty FIFO with the FSM in IDLE drives tx low (start bit) from edge k+1.
- States and transitions:
  - IDLE: tx=1. Leaves to START when !empty.
  - START: tx=0 for ClocksPerBit cycles, then DATA.
  - DATA: tx = shift register LSB. Shifts right every ClocksPerBit cycles. After NrOfDataBits bits, goes to PARITY (if enabled) else STOP.
  - PARITY: tx = parity bit for ClocksPerBit cycles, then STOP.
  - STOP: tx=1 for NrOfStopBits*ClocksPerBit cycles. At completion:
    - If !empty, pop and go to START on the same edge; no idle gap between frames.
    - Else go to IDLE.
- Baud counter: counts 0..ClocksPerBit-1, reloads to 0 on each bit boundary. Width = clog2(ClocksPerBit).
- Bit counter width: clog2(NrOfDataBits+1). FIFO count width: clog2(FifoDepth)+1. Pointers wrap modulo FifoDepth.
- All outputs are registered except full and empty, which are decoded from the registered count.
- writeData is sampled only on the write edge; later changes do not affect stored data.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state present. Parity bit = XOR of data bits (even), inverted when ParityOdd=1. Frame length = 1 + NrOfDataBits + 1 + NrOfStopBits bits.
- Undefined: no PARITY state and no parity logic. ParityOdd is ignored. Frame length = 1 + NrOfDataBits + NrOfStopBits bits.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants (PARITY_EVEN=0, PARITY_ODD=1);
  - a constant function computing ClocksPerBit with an elaboration-time check that it is >= 2.
- One sub-module: sync_fifo, parametrised by width and depth, exposing write/read/full/empty/count. uart_tx_fifo instantiates it and contains only the FSM and datapath.

Test Plan:
(Bench uses ClockFrequency=8, BaudRate=1, so ClocksPerBit=8.)
- Single byte, no parity: write 8'hA5.
  - tx low from the next edge for 8 cycles.
  - Then 1,0,1,0,0,1,0,1 at 8 cycles each, then high.
  - busy deasserts 80 cycles after the start bit began; empty=1.
- Back-to-back: write 8'h55, 8'h0F in consecutive cycles.
  - Second start bit immediately follows the first stop bit, with no extra idle cycle.
  - Total busy time = 160 cycles.
- Overflow: FifoDepth=4. Write 6 bytes in 6 consecutive cycles while idle.
  - Byte 1 popped at once, so 5 accepted; full asserts.
  - 6th write pulses overflow for 1 cycle.
  - Exactly 5 frames appear on tx.
- Parity (UART_TX_PARITY_EN defined):
  - 8'hA5 with ParityOdd=0 → parity bit 0.
  - 8'hA5 with ParityOdd=1 → parity bit 1.
  - 8'h07 with ParityOdd=0 → parity bit 1.
- Two stop bits, NrOfDataBits=7: write 7'h41. Frame = start, 1,0,0,0,0,0,1, then tx high for 16 cycles before busy falls.
- Reset mid-frame: assert reset during the DATA bit 3 of a frame with 2 bytes queued.
  - tx=1 and empty=1 asynchronously.
  - After release, no frame is transmitted until a new write.
